mem_wb_writeback: RTL and testbench

//  MEM/WB pipeline register and writeback stage of the RISC-V core; sits directly upstream of the register bank.

---
 rtl/mem_wb_writeback.sv | 188 ++++++++++++++++++
 tb/tb_mem_wb_writeback.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback
// MEM/WB pipeline register plus writeback select for the RISC-V core. The
// captured MEM-stage result drives the register bank (which writes on the
// following negedge), the forwarding unit, a retired-instruction counter and a
// sticky misaligned-load flag.
//
// Ports:
//   clk, rst_n       clock (posedge state updates), async active-low reset
//   in_valid         MEM stage presents a real instruction
//   stall            hold the WB entry, ignore MEM inputs
//   flush            replace the WB entry with a bubble (wins over stall)
//   in_rd            destination register
//   in_reg_write     instruction writes rd
//   in_wb_sel        00 ALU, 01 LOAD, 10 PC+4, 11 IMM
//   in_funct3        load size/sign (LB, LH, LW, LBU, LHU)
//   in_alu_result    ALU result, bits [1:0] are the load byte offset
//   in_pc_plus4      link value for JAL/JALR
//   in_imm           U-type immediate
//   mem_rdata        raw aligned data-memory word
//   rd, write_data, reg_write   register bank write port
//   wb_valid         WB holds a real instruction
//   fwd_en           reg_write with a non-zero rd
//   retire_count     instructions that left WB (wraps)
//   misalign_err     sticky misaligned/illegal load indicator
//
// Transfer rule: there is no ready back-pressure; an entry moves from MEM into
// WB on every posedge where flush=0 and stall=0, and an entry leaves WB
// (retires) on every posedge where it is valid and either stall=0 or flush=1.
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  output logic              wb_valid,
  output logic              fwd_en,
  output logic [CNT_W-1:0]  retire_count,
  output logic              misalign_err
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  logic              v_q;
  logic              rw_q;
  logic [4:0]        rd_q;
  logic [1:0]        sel_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] pc4_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic [1:0]        off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] load_data;
  logic              bad_align;
  logic              misaligned;
  logic [DATA_W-1:0] sel_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      sel_q   <= '0;
      f3_q    <= '0;
      alu_q   <= '0;
      pc4_q   <= '0;
      imm_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (flush) begin
        v_q     <= 1'b0;
        rw_q    <= 1'b0;
        rd_q    <= '0;
        sel_q   <= '0;
        f3_q    <= '0;
        alu_q   <= '0;
        pc4_q   <= '0;
        imm_q   <= '0;
        rdata_q <= '0;
      end else if (!stall) begin
        v_q     <= in_valid;
        // A non-instruction must never write the bank.
        rw_q    <= in_reg_write & in_valid;
        rd_q    <= in_rd;
        sel_q   <= in_wb_sel;
        f3_q    <= in_funct3;
        alu_q   <= in_alu_result;
        pc4_q   <= in_pc_plus4;
        imm_q   <= in_imm;
        rdata_q <= mem_rdata;
      end

      // Retire when the valid entry is displaced, by a new capture or a flush.
      if (v_q && (!stall || flush)) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (v_q && misaligned) begin
        err_q <= 1'b1;
      end
    end
  end

  assign off = alu_q[1:0];

  always_comb begin
    ld_byte = rdata_q[7:0];
    case (off)
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
  end

  assign ld_half = off[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_data = '0;
    bad_align = 1'b0;
    case (f3_q)
      3'b000: load_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b001: begin
        load_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
        bad_align = off[0];
      end
      3'b010: begin
        load_data = rdata_q;
        bad_align = (off != 2'd0);
      end
      3'b100: load_data = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b101: begin
        load_data = {{(DATA_W-16){1'b0}}, ld_half};
        bad_align = off[0];
      end
      // 011, 110, 111 are not legal load encodings.
      default: bad_align = 1'b1;
    endcase
  end

  // funct3 only matters for loads; other selects ignore it entirely.
  assign misaligned = (sel_q == SEL_LOAD) && bad_align;

  always_comb begin
    sel_data = alu_q;
    case (sel_q)
      SEL_ALU:  sel_data = alu_q;
      SEL_LOAD: sel_data = load_data;
      SEL_PC4:  sel_data = pc4_q;
      SEL_IMM:  sel_data = imm_q;
      default:  sel_data = alu_q;
    endcase
  end

  assign write_data   = misaligned ? '0 : sel_data;
  assign reg_write    = v_q & rw_q & ~misaligned;
  assign rd           = rd_q;
  assign wb_valid     = v_q;
  // x0 writes still reach the bank (it ignores them) but are never forwarded.
  assign fwd_en       = reg_write && (rd_q != 5'd0);
  assign retire_count = cnt_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
module tb_mem_wb_writeback;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [4:0]        in_rd;
  logic              in_reg_write;
  logic [1:0]        in_wb_sel;
  logic [2:0]        in_funct3;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_pc_plus4;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] mem_rdata;
  logic [4:0]        rd;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic              wb_valid;
  logic              fwd_en;
  logic [CNT_W-1:0]  retire_count;
  logic              misalign_err;

  int checks = 0;
  int errors = 0;

  mem_wb_writeback #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_wb_sel     (in_wb_sel),
    .in_funct3     (in_funct3),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .in_imm        (in_imm),
    .mem_rdata     (mem_rdata),
    .rd            (rd),
    .write_data    (write_data),
    .reg_write     (reg_write),
    .wb_valid      (wb_valid),
    .fwd_en        (fwd_en),
    .retire_count  (retire_count),
    .misalign_err  (misalign_err)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // The WB entry as an instruction record, evaluated from the ISA load rules.
  bit          m_valid;
  bit          m_rw;
  logic [4:0]  m_rd;
  int          m_sel;
  int          m_f3;
  logic [31:0] m_alu;
  logic [31:0] m_pc4;
  logic [31:0] m_imm;
  logic [31:0] m_rdata;
  int          m_count;
  bit          m_err;

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_rd = '0; m_sel = 0; m_f3 = 0;
    m_alu = '0; m_pc4 = '0; m_imm = '0; m_rdata = '0;
    m_count = 0; m_err = 0;
  endtask

  function automatic int load_size(int f3);
    if (f3 == 0 || f3 == 4) return 1;
    if (f3 == 1 || f3 == 5) return 2;
    if (f3 == 2) return 4;
    return 0; // illegal encoding
  endfunction

  function automatic bit m_mis();
    int sz;
    int byte_off;
    if (m_sel != 1) return 0;
    sz = load_size(m_f3);
    if (sz == 0) return 1;
    byte_off = int'(m_alu) & 3;
    return (byte_off % sz) != 0;
  endfunction

  function automatic logic [31:0] m_wd();
    longint v;
    longint span;
    int sz;
    int byte_off;
    if (m_mis()) return 32'h0;
    if (m_sel == 0) return m_alu;
    if (m_sel == 2) return m_pc4;
    if (m_sel == 3) return m_imm;
    sz = load_size(m_f3);
    byte_off = int'(m_alu) & 3;
    span = longint'(1) << (8 * sz);
    v = (longint'(m_rdata) >> (8 * byte_off)) % span;
    // funct3 values below 4 are the signed loads.
    if (m_f3 < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic bit m_reg_write();
    return m_valid && m_rw && !m_mis();
  endfunction

  function automatic logic [CNT_W-1:0] m_cnt();
    int c;
    c = m_count % (1 << CNT_W);
    return c[CNT_W-1:0];
  endfunction

  // Applies one posedge worth of rules using the inputs present before it.
  task automatic model_step();
    bit mis;
    mis = m_mis();
    if (m_valid && (!stall || flush)) m_count = m_count + 1;
    if (m_valid && mis) m_err = 1;
    if (flush) begin
      m_valid = 0; m_rw = 0; m_rd = '0;
    end else if (!stall) begin
      m_valid = in_valid;
      m_rw    = in_valid && in_reg_write;
      m_rd    = in_rd;
      m_sel   = int'(in_wb_sel);
      m_f3    = int'(in_funct3);
      m_alu   = in_alu_result;
      m_pc4   = in_pc_plus4;
      m_imm   = in_imm;
      m_rdata = mem_rdata;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic set_op(input bit v, input bit rw, input logic [4:0] r,
                        input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [31:0] imm, input logic [31:0] rdata);
    in_valid = v; in_reg_write = rw; in_rd = r; in_wb_sel = sel;
    in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc4;
    in_imm = imm; mem_rdata = rdata;
  endtask

  task automatic set_idle();
    set_op(0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_idle();
    model_reset();
    #12;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got=%b exp=0", reg_write); end
    checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", rd); end
    checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL reset_write_data got=%h exp=0", write_data); end
    checks++; if (retire_count !== '0) begin errors++; $display("FAIL reset_retire got=%0d exp=0", retire_count); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
    checks++; if (fwd_en !== 1'b0) begin errors++; $display("FAIL reset_fwd_en got=%b exp=0", fwd_en); end
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    set_op(1, 1, 5'd5, 2'b00, 3'b010, 32'h1234_5678, 32'h0, 32'h0, 32'hDEAD_BEEF);
    tick();
    set_idle();
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL alu_reg_write got=%b exp=1", reg_write); end
    checks++; if (rd !== 5'd5) begin errors++; $display("FAIL alu_rd got=%0d exp=5", rd); end
    checks++; if (write_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_write_data got=%h exp=12345678", write_data); end
    checks++; if (fwd_en !== 1'b1) begin errors++; $display("FAIL alu_fwd_en got=%b exp=1", fwd_en); end
    checks++; if (retire_count !== 4'd0) begin errors++; $display("FAIL alu_count_before got=%0d exp=0", retire_count); end
    tick();
    checks++; if (retire_count !== 4'd1) begin errors++; $display("FAIL alu_count_after got=%0d exp=1", retire_count); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_bubble_valid got=%b exp=0", wb_valid); end
  endtask

  task automatic test_load_extract();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0]  offs [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    logic [31:0] exps [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                              32'hFFFF_80FF, 32'h0000_80FF};
    for (int i = 0; i < 5; i++) begin
      set_op(1, 1, 5'd3, 2'b01, f3s[i], {28'h0000_100, 2'b00, offs[i]},
             32'h0, 32'h0, 32'h80FF_7F01);
      tick();
      checks++; if (write_data !== exps[i]) begin errors++; $display("FAIL load_data[%0d] got=%h exp=%h", i, write_data, exps[i]); end
      checks++; if (write_data !== m_wd()) begin errors++; $display("FAIL load_model[%0d] got=%h exp=%h", i, write_data, m_wd()); end
      checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL load_reg_write[%0d] got=%b exp=1", i, reg_write); end
    end
    set_idle();
    tick();
  endtask

  task automatic test_misalign();
    int base;
    set_op(1, 1, 5'd7, 2'b01, 3'b010, 32'h0000_2002, 32'h0, 32'h0, 32'h1111_2222);
    tick();
    base = m_count;
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL mis_reg_write got=%b exp=0", reg_write); end
    checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL mis_write_data got=%h exp=0", write_data); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_err_early got=%b exp=0", misalign_err); end
    set_op(1, 1, 5'd2, 2'b00, 3'b000, 32'h0000_0042, 32'h0, 32'h0, 32'h0);
    tick();
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err_set got=%b exp=1", misalign_err); end
    checks++; if (retire_count !== CNT_W'(base + 1)) begin errors++; $display("FAIL mis_count got=%0d exp=%0d", retire_count, CNT_W'(base + 1)); end
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL mis_next_good got=%b exp=1", reg_write); end
    set_idle();
    tick();
    tick();
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err_sticky got=%b exp=1", misalign_err); end
  endtask

  task automatic test_stall();
    logic [CNT_W-1:0] base;
    set_op(1, 1, 5'd9, 2'b00, 3'b000, 32'h0000_A5A5, 32'h0, 32'h0, 32'h0);
    tick();
    base = m_cnt();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(1, 1, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 3'b010,
             $urandom, $urandom, $urandom, $urandom);
      tick();
      checks++; if (write_data !== 32'h0000_A5A5) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=0000a5a5", i, write_data); end
      checks++; if (rd !== 5'd9 || reg_write !== 1'b1) begin errors++; $display("FAIL stall_rd_rw[%0d] got=%0d/%b exp=9/1", i, rd, reg_write); end
      checks++; if (retire_count !== base) begin errors++; $display("FAIL stall_count[%0d] got=%0d exp=%0d", i, retire_count, base); end
    end
    stall = 1'b0;
    set_idle();
    tick();
    checks++; if (retire_count !== base + 4'd1) begin errors++; $display("FAIL stall_release_count got=%0d exp=%0d", retire_count, base + 4'd1); end
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] base;
    set_op(1, 1, 5'd4, 2'b11, 3'b000, 32'h0, 32'h0, 32'hABCD_E000, 32'h0);
    tick();
    base = m_cnt();
    checks++; if (write_data !== 32'hABCD_E000) begin errors++; $display("FAIL flush_lui got=%h exp=abcde000", write_data); end
    stall = 1'b1; flush = 1'b1;
    tick();
    checks++; if (wb_valid !== 1'b0 || reg_write !== 1'b0) begin errors++; $display("FAIL flush_stall_bubble got=%b/%b exp=0/0", wb_valid, reg_write); end
    checks++; if (retire_count !== base + 4'd1) begin errors++; $display("FAIL flush_stall_count got=%0d exp=%0d", retire_count, base + 4'd1); end
    stall = 1'b0;
    set_op(1, 1, 5'd6, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 32'h0);
    tick();
    checks++; if (wb_valid !== 1'b0 || rd !== 5'd0) begin errors++; $display("FAIL flush_in_valid got=%b/%0d exp=0/0", wb_valid, rd); end
    checks++; if (retire_count !== base + 4'd1) begin errors++; $display("FAIL flush_no_count got=%0d exp=%0d", retire_count, base + 4'd1); end
    flush = 1'b0;
    set_idle();
    tick();
  endtask

  task automatic test_async_reset();
    set_op(1, 1, 5'd12, 2'b00, 3'b000, 32'h5555_0000, 32'h0, 32'h0, 32'h0);
    stall = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (wb_valid !== 1'b0 || reg_write !== 1'b0 || fwd_en !== 1'b0) begin errors++; $display("FAIL areset_ctrl got=%b%b%b exp=000", wb_valid, reg_write, fwd_en); end
    checks++; if (rd !== 5'd0 || write_data !== 32'h0) begin errors++; $display("FAIL areset_data got=%0d/%h exp=0/0", rd, write_data); end
    checks++; if (retire_count !== '0 || misalign_err !== 1'b0) begin errors++; $display("FAIL areset_cnt_err got=%0d/%b exp=0/0", retire_count, misalign_err); end
    tick();
    stall = 1'b0;
    #2;
    rst_n = 1'b1;
    set_op(1, 1, 5'd1, 2'b10, 3'b000, 32'h0000_0FFF, 32'h0000_0104, 32'h0, 32'h0);
    tick();
    set_idle();
    checks++; if (write_data !== 32'h0000_0104) begin errors++; $display("FAIL jal_data got=%h exp=00000104", write_data); end
    checks++; if (rd !== 5'd1 || reg_write !== 1'b1) begin errors++; $display("FAIL jal_rd_rw got=%0d/%b exp=1/1", rd, reg_write); end
    checks++; if (retire_count !== '0) begin errors++; $display("FAIL jal_count got=%0d exp=0", retire_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 8);
      set_op($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 85,
             5'($urandom_range(0, 31)),
             ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom);
      tick();
      checks++; if (wb_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, wb_valid, m_valid); end
      checks++; if (reg_write !== m_reg_write()) begin errors++; $display("FAIL rnd_reg_write[%0d] got=%b exp=%b", i, reg_write, m_reg_write()); end
      checks++; if (rd !== m_rd) begin errors++; $display("FAIL rnd_rd[%0d] got=%0d exp=%0d", i, rd, m_rd); end
      checks++; if (fwd_en !== (m_reg_write() && m_rd != 5'd0)) begin errors++; $display("FAIL rnd_fwd_en[%0d] got=%b", i, fwd_en); end
      checks++; if (retire_count !== m_cnt()) begin errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, retire_count, m_cnt()); end
      checks++; if (misalign_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got=%b exp=%b", i, misalign_err, m_err); end
      if (m_valid) begin
        checks++; if (write_data !== m_wd()) begin errors++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, write_data, m_wd()); end
      end
    end
    stall = 1'b0;
    flush = 1'b0;
    set_idle();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu();
    test_load_extract();
    test_misalign();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
